branch_update_queue: RTL

// - In-flight branch tracker; producer side of the local predictor's counter-update interface.
// - Fetch allocates one entry per predicted branch, holding PC and the 2-bit counter snapshot read at prediction time.
// - Execute resolves entries by tag, in any order. Entries retire strictly in order from the head.
// - Each retirement emits one update beat: PC, taken, old counter, update strobe. Also flags a mispredict.

---
 rtl/bp_pkg.sv | 15 +
 rtl/branch_update_queue.sv | 90 +++++++++
 2 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared widths, queue entry layout and mispredict helper for the branch predictor.
package bp_pkg;
  localparam int PC_W = 10;
  localparam int CNT_W = 2;
  typedef struct packed {
    logic             valid;
    logic             resolved;
    logic             taken;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] counter;
  } bq_entry_t;
  function automatic logic is_mispredict(input logic [CNT_W-1:0] counter, input logic taken);
    return counter[CNT_W-1] != taken;
  endfunction
endpackage

// File: rtl/branch_update_queue.sv
// branch_update_queue: in-flight branch tracker, resolves out of order, retires in order as predictor updates.
module branch_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [PC_W-1:0]  alloc_pc,
  input  logic [CNT_W-1:0] alloc_counter,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  input  logic             commit_en,
  input  logic             flush,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_taken,
  output logic [CNT_W-1:0] upd_counter,
  output logic             upd_mispredict,
  output logic [TAG_W:0]   occupancy
);
  bq_entry_t        ent_q [DEPTH];
  bq_entry_t        ent_d [DEPTH];
  bq_entry_t        head_ent;
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   occ_q, occ_d;
  logic             upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
  logic [CNT_W-1:0] upd_counter_q, upd_counter_d;
  logic             alloc_fire, retire, res_ok, emit;
  assign alloc_ready    = occ_q != (TAG_W+1)'(DEPTH);
  assign alloc_tag      = tail_q;
  assign occupancy      = occ_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign upd_counter    = upd_counter_q;
  assign upd_mispredict = upd_valid_q & is_mispredict(upd_counter_q, upd_taken_q);
  always_comb begin
    head_ent   = ent_q[head_q];
    alloc_fire = alloc_valid & alloc_ready;
    retire     = head_ent.valid & head_ent.resolved & commit_en;
    res_ok     = resolve_valid & ent_q[resolve_tag].valid & ~ent_q[resolve_tag].resolved;
    emit       = retire & ~flush;
    ent_d      = ent_q;
    if (res_ok) begin
      ent_d[resolve_tag].resolved = 1'b1;
      ent_d[resolve_tag].taken    = resolve_taken;
    end
    if (retire) ent_d[head_q].valid = 1'b0;
    if (alloc_fire)
      ent_d[tail_q] = '{valid: 1'b1, resolved: 1'b0, taken: 1'b0, pc: alloc_pc, counter: alloc_counter};
    // power-of-two depth lets the pointers wrap by plain overflow
    head_d        = flush ? '0 : head_q + TAG_W'(retire);
    tail_d        = flush ? '0 : tail_q + TAG_W'(alloc_fire);
    occ_d         = flush ? '0 : occ_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
    upd_valid_d   = emit;
    upd_pc_d      = emit ? head_ent.pc : upd_pc_q;
    upd_taken_d   = emit ? head_ent.taken : upd_taken_q;
    upd_counter_d = emit ? head_ent.counter : upd_counter_q;
    if (flush)
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      occ_q         <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      upd_counter_q <= '0;
    end else begin
      ent_q         <= ent_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      occ_q         <= occ_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      upd_counter_q <= upd_counter_d;
    end
  end
endmodule
